// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through rows 000..111, holding each for SETTLE_CYCLES, and grades its 8-bit truth-table code.
// Latency: done pulses in the cycle after edge E0+8*SETTLE_CYCLES, where E0 is the edge that accepts start.
// Backpressure: none; start is ignored (not queued) while a sweep is active, abort returns to IDLE, and
// the optional TT_STABLE_CHECK_EN build adds an unstable[7:0] output for samples that change just before the row sample.
module truth_table_sweeper #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] EXPECTED      = 8'h00,
    parameter int         CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
    output logic [7:0] mismatch
`ifdef TT_STABLE_CHECK_EN
    ,
    output logic [7:0] unstable
`endif
);

    // A settle time of 0 would never sample, so it behaves as 1.
    localparam int               SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(SETTLE_EFF - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [2:0]       row;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       table_next;
    logic             pass_next;

    // The gate inputs come straight from the row register, so they are glitch-free flop outputs.
    assign dut_in1 = row[2];
    assign dut_in2 = row[1];
    assign dut_in3 = row[0];

`ifdef TT_STABLE_CHECK_EN
    logic       pre_sample;
    logic [7:0] unstable_next;

    // Flag the current row when the early sample disagrees with the row sample.
    always_comb begin
        unstable_next = unstable;
        if (SETTLE_EFF >= 2) begin
            unstable_next[~row] = pre_sample ^ dut_out;
        end
    end

    // Capture the gate output one cycle before the row sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_sample <= 1'b0;
        end else if (state == ST_DRIVE && cnt == CNT_W'(1)) begin
            pre_sample <= dut_out;
        end
    end
`endif

    // Table as it will look once the current row's sample is written; bit (7-row) is ~row.
    always_comb begin
        table_next       = table_out;
        table_next[~row] = dut_out;
`ifdef TT_STABLE_CHECK_EN
        pass_next = (table_next == EXPECTED) && (unstable_next == 8'h00);
`else
        pass_next = (table_next == EXPECTED);
`endif
    end

    // Sweep sequencer: IDLE waits for start, DRIVE walks the rows, DONE emits the result pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            row       <= 3'd0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= 8'h00;
            mismatch  <= 8'h00;
`ifdef TT_STABLE_CHECK_EN
            unstable  <= 8'h00;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort beats a simultaneous start
                    if (start && !abort) begin
                        state     <= ST_DRIVE;
                        row       <= 3'd0;
                        cnt       <= RELOAD;
                        table_out <= 8'h00;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
`ifdef TT_STABLE_CHECK_EN
                        unstable  <= 8'h00;
`endif
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        // Partial table_out bits stay visible for debug.
                        state <= ST_IDLE;
                        row   <= 3'd0;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        table_out <= table_next;
`ifdef TT_STABLE_CHECK_EN
                        unstable  <= unstable_next;
`endif
                        if (row != 3'd7) begin
                            row <= row + 3'd1;
                            cnt <= RELOAD;
                        end else begin
                            // Row stays at 7 for the DONE cycle and returns to 000 afterwards.
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= pass_next;
                            mismatch <= table_next ^ EXPECTED;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    row   <= 3'd0;
                    if (abort) begin
                        pass <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    row   <= 3'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 / expected 7B, settle 1 / expected A5) against a gate model.
// Latency: expected row/done timing derived from E0 + k cycles, sampled on the falling edge.
// Backpressure: exercises start noise, abort, start+abort in IDLE and mid-sweep reset.
module tb_truth_table_sweeper;

    localparam int         S0   = 4;
    localparam logic [7:0] EXP0 = 8'h7B;
    localparam int         S1   = 1;
    localparam logic [7:0] EXP1 = 8'hA5;

    logic       clk = 1'b0;
    logic       reset, start, abort, start1;
    logic [7:0] gate_code, gate1_code;
    logic       force_en, force_val, glitch_on;
    logic [2:0] force_row;

    logic       dut_out0, dut_in1, dut_in2, dut_in3, busy, done, pass;
    logic [7:0] table_out, mismatch;
    logic       dut_out1, d1_in1, d1_in2, d1_in3, busy1, done1, pass1;
    logic [7:0] table1, mismatch1;
    logic [2:0] row0, row1;
`ifdef TT_STABLE_CHECK_EN
    logic [7:0] unstable, unstable1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign row0 = {dut_in1, dut_in2, dut_in3};
    assign row1 = {d1_in1, d1_in2, d1_in3};

    // Gate models: the truth-table code indexed by row, with optional stuck value and late glitch.
    assign dut_out0 = (force_en && row0 == force_row) ? force_val : (gate_code[3'd7 - row0] ^ glitch_on);
    assign dut_out1 = gate1_code[3'd7 - row1];

    truth_table_sweeper #(.SETTLE_CYCLES(S0), .EXPECTED(EXP0), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .dut_out(dut_out0),
        .dut_in1(dut_in1), .dut_in2(dut_in2), .dut_in3(dut_in3),
        .busy(busy), .done(done), .pass(pass), .table_out(table_out), .mismatch(mismatch)
`ifdef TT_STABLE_CHECK_EN
        , .unstable(unstable)
`endif
    );

    truth_table_sweeper #(.SETTLE_CYCLES(S1), .EXPECTED(EXP1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(1'b0), .dut_out(dut_out1),
        .dut_in1(d1_in1), .dut_in2(d1_in2), .dut_in3(d1_in3),
        .busy(busy1), .done(done1), .pass(pass1), .table_out(table1), .mismatch(mismatch1)
`ifdef TT_STABLE_CHECK_EN
        , .unstable(unstable1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Full sweep on instance 0; expectations come from the gate code and the row schedule k/S0.
    task automatic sweep0(input logic [7:0] code, input bit noise, input bit glitch);
        logic [7:0] exp_tab;
        logic [7:0] exp_unst;
        gate_code = code;
        exp_tab   = code;
        if (force_en) exp_tab[3'd7 - force_row] = force_val;
        exp_unst = 8'h00;
        if (glitch) begin
            exp_tab[5] = ~exp_tab[5];
            exp_unst   = 8'h20;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 8 * S0; k++) begin
            check("row", 32'(row0), 32'(k / S0));
            check("busy", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            glitch_on = glitch && (k == 3 * S0 - 1);
            @(negedge clk);
        end
        start     = 1'b0;
        glitch_on = 1'b0;
        check("done", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("table", 32'(table_out), 32'(exp_tab));
        check("mismatch", 32'(mismatch), 32'(exp_tab ^ EXP0));
        check("pass", 32'(pass), 32'(exp_tab == EXP0 && exp_unst == 8'h00));
`ifdef TT_STABLE_CHECK_EN
        check("unstable", 32'(unstable), 32'(exp_unst));
`endif
        @(negedge clk);
        check("done_1cyc", 32'(done), 32'd0);
        check("row_idle", 32'(row0), 32'd0);
        check("pass_hold", 32'(pass), 32'(exp_tab == EXP0 && exp_unst == 8'h00));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    // Sweep on the settle-1 instance: one row per cycle.
    task automatic sweep1(input logic [7:0] code);
        gate1_code = code;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("s1_row", 32'(row1), 32'(k));
            check("s1_done_early", 32'(done1), 32'd0);
            @(negedge clk);
        end
        check("s1_done", 32'(done1), 32'd1);
        check("s1_table", 32'(table1), 32'(code));
        check("s1_pass", 32'(pass1), 32'(code == EXP1));
        check("s1_mismatch", 32'(mismatch1), 32'(code ^ EXP1));
    endtask

    initial begin
        int seen;
        logic [7:0] code;
        reset = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
        gate_code = 8'h00; gate1_code = 8'h00;
        force_en = 1'b0; force_val = 1'b0; force_row = 3'd0; glitch_on = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_row", 32'(row0), 32'd0);
        check("rst_table", 32'(table_out), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);

        // Matching gate, then random gates with start noise.
        sweep0(EXP0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            code = 8'($urandom);
            sweep0(code, 1'b1, 1'b0);
        end

        // Row 101 stuck at 0 (matches) then stuck at 1 (bit 2 mismatch).
        force_en = 1'b1; force_row = 3'd5; force_val = 1'b0;
        sweep0(EXP0, 1'b0, 1'b0);
        force_val = 1'b1;
        sweep0(EXP0, 1'b0, 1'b0);
        force_en = 1'b0;

        // Abort mid row 3.
        code = 8'($urandom);
        gate_code = code;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3 * S0 + 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_table", 32'(table_out), 32'({code[7:5], 5'b0}));
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_row", 32'(row0), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // start and abort together in IDLE: nothing starts.
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy || row0 != 3'd0) seen++;
            @(negedge clk);
        end
        check("start_abort_idle", 32'(seen), 32'd0);

        // Reset mid-sweep, then a full sweep with normal timing.
        gate_code = 8'hFF;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1; reset = 1'b1;
        @(negedge clk); start = 1'b0; reset = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_table", 32'(table_out), 32'd0);
        check("mrst_row", 32'(row0), 32'd0);
        check("mrst_pass", 32'(pass), 32'd0);
        check("mrst_mismatch", 32'(mismatch), 32'd0);
        sweep0(8'($urandom), 1'b0, 1'b0);

`ifdef TT_STABLE_CHECK_EN
        sweep0(EXP0, 1'b0, 1'b1);
`endif

        // Settle time of one cycle.
        sweep1(EXP1);
        for (int i = 0; i < 3; i++) sweep1(8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
